// File: rtl/muldiv_sequencer.sv
// Multicycle MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO pair.
// Multiply takes two registered stages; divide is a 32-step restoring divider.
module muldiv_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_is_div;
  logic        r_dz;
  logic        r_mul_stage;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [5:0]  r_cnt;
  logic [31:0] r_a_mag;
  logic [31:0] r_b_mag;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_pp_ll;
  logic [31:0] r_pp_lh;
  logic [31:0] r_pp_hl;
  logic [31:0] r_pp_hh;

  function automatic logic [31:0] f_abs32(input logic [31:0] v, input logic en);
    f_abs32 = (en && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] f_neg32(input logic [31:0] v, input logic en);
    f_neg32 = en ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] f_neg64(input logic [63:0] v, input logic en);
    f_neg64 = en ? (~v + 64'd1) : v;
  endfunction

  logic        w_signed;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_neg_q;
  logic        w_neg_r;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic [63:0] w_prod_mag;
  logic [63:0] w_prod;
  logic [31:0] w_hi_res;
  logic [31:0] w_lo_res;
  logic        w_wb;

  // Operand conditioning, divider step, product summation and writeback select.
  always_comb begin
    w_signed   = ~op[0];
    w_a_mag    = f_abs32(a, w_signed);
    w_b_mag    = f_abs32(b, w_signed);
    w_neg_q    = w_signed & (a[31] ^ b[31]);
    w_neg_r    = w_signed & a[31];
    w_shift    = {r_rem, r_quo[31]};
    w_diff     = w_shift - {1'b0, r_b_mag};
    w_prod_mag = {r_pp_hh, 32'd0}
               + {16'd0, r_pp_lh, 16'd0}
               + {16'd0, r_pp_hl, 16'd0}
               + {32'd0, r_pp_ll};
    w_prod     = f_neg64(w_prod_mag, r_neg_q);
    // Product is already signed in r_rem/r_quo; only divide results need fixing up.
    w_hi_res   = f_neg32(r_rem, r_is_div & r_neg_r);
    w_lo_res   = f_neg32(r_quo, r_is_div & r_neg_q);
    w_wb       = (r_state == S_DONE) && !flush && !r_dz;
  end

  // Sequencer FSM with registered status outputs and HI/LO ownership.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_is_div    <= 1'b0;
      r_dz        <= 1'b0;
      r_mul_stage <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_cnt       <= 6'd0;
      r_a_mag     <= 32'd0;
      r_b_mag     <= 32'd0;
      r_rem       <= 32'd0;
      r_quo       <= 32'd0;
      r_pp_ll     <= 32'd0;
      r_pp_lh     <= 32'd0;
      r_pp_hl     <= 32'd0;
      r_pp_hh     <= 32'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_zero    <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      if (hi_we && !w_wb) begin
        hi <= wdata;
      end else begin
        hi <= hi;
      end
      if (lo_we && !w_wb) begin
        lo <= wdata;
      end else begin
        lo <= lo;
      end

      if (flush) begin
        r_state     <= S_IDLE;
        r_mul_stage <= 1'b0;
        r_cnt       <= 6'd0;
        busy        <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_a_mag     <= w_a_mag;
              r_b_mag     <= w_b_mag;
              r_neg_q     <= w_neg_q;
              r_neg_r     <= w_neg_r;
              r_is_div    <= op[1];
              r_dz        <= op[1] && (b == 32'd0);
              r_mul_stage <= 1'b0;
              r_cnt       <= 6'd0;
              busy        <= 1'b1;
              if (!op[1]) begin
                r_state <= S_MUL;
              end else if (b == 32'd0) begin
                r_state <= S_DONE;
              end else begin
                r_state <= S_DIV;
                r_rem   <= 32'd0;
                r_quo   <= w_a_mag;
              end
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_MUL: begin
            if (!r_mul_stage) begin
              r_pp_ll     <= {16'd0, r_a_mag[15:0]}  * {16'd0, r_b_mag[15:0]};
              r_pp_lh     <= {16'd0, r_a_mag[15:0]}  * {16'd0, r_b_mag[31:16]};
              r_pp_hl     <= {16'd0, r_a_mag[31:16]} * {16'd0, r_b_mag[15:0]};
              r_pp_hh     <= {16'd0, r_a_mag[31:16]} * {16'd0, r_b_mag[31:16]};
              r_mul_stage <= 1'b1;
            end else begin
              r_rem       <= w_prod[63:32];
              r_quo       <= w_prod[31:0];
              r_mul_stage <= 1'b0;
              r_state     <= S_DONE;
            end
          end
          S_DIV: begin
            // Restoring step: keep the trial subtraction only when it did not borrow.
            if (!w_diff[32]) begin
              r_rem <= w_diff[31:0];
              r_quo <= {r_quo[30:0], 1'b1};
            end else begin
              r_rem <= w_shift[31:0];
              r_quo <= {r_quo[30:0], 1'b0};
            end
            if (r_cnt == 6'd31) begin
              r_cnt   <= 6'd0;
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end
          S_DONE: begin
            done     <= 1'b1;
            div_zero <= r_dz;
            if (!r_dz) begin
              hi <= w_hi_res;
              lo <= w_lo_res;
            end
            r_dz    <= 1'b0;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed operations push expected
// HI/LO/div_zero and completion cycle; a monitor checks each done pulse.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edz;
    int          due;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_done = 0;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      exp_t e;
      n_done++;
      if (q.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        chk({e.name, "_hi"}, {32'd0, hi}, {32'd0, e.ehi});
        chk({e.name, "_lo"}, {32'd0, lo}, {32'd0, e.elo});
        chk({e.name, "_dz"}, {63'd0, div_zero}, {63'd0, e.edz});
        chk({e.name, "_cycle"}, 64'(cyc), 64'(e.due));
      end
    end
  end

  // Called at a negedge: start is sampled on the next rising edge.
  task automatic issue(input string name, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                       input logic edz, input int lat);
    exp_t e;
    e.name = name; e.ehi = ehi; e.elo = elo; e.edz = edz; e.due = cyc + 1 + lat;
    q.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = OP_DIV; a = 32'hDEADBEEF; b = 32'd0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("drain_in_time", 64'(q.size()), 64'd0);
    q.delete();
    @(negedge clk);
  endtask

  initial begin
    int n_before;
    rst = 1'b0; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dz", {63'd0, div_zero}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    rst = 1'b1;

    // MULT -2*3 with busy profile
    issue("mult_neg", OP_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 3);
    chk("mult_busy1", {63'd0, busy}, 64'd1);
    @(negedge clk); chk("mult_busy2", {63'd0, busy}, 64'd1);
    @(negedge clk); chk("mult_busy3", {63'd0, busy}, 64'd1);
    @(negedge clk); chk("mult_busy_end", {63'd0, busy}, 64'd0);
    drain();

    issue("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 3);
    drain();
    issue("mult_minmin", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 3);
    drain();
    issue("mult_m1x1", OP_MULT, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 3);
    drain();
    issue("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
    drain();
    issue("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
    drain();
    issue("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 33);
    drain();
    issue("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 33);
    drain();
    issue("divu_big", OP_DIVU, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 1'b0, 33);
    drain();

    // Direct writes then divide by zero leaves HI/LO alone
    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
    @(negedge clk); lo_we = 1'b0;
    chk("mthi_mtlo", {hi, lo}, {32'h1234, 32'h5678});
    issue("divu_zero", OP_DIVU, 32'd100, 32'd0, 32'h1234, 32'h5678, 1'b1, 1);
    drain();

    // Flush at divide iteration 10
    n_before = n_done;
    issue("div_flushed", OP_DIV, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 33);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    q.delete();
    repeat (40) @(negedge clk);
    chk("flush_no_done", 64'(n_done), 64'(n_before));
    chk("flush_hilo", {hi, lo}, {32'h1234, 32'h5678});
    issue("multu_5x6", OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 3);
    drain();

    // Flush beats a simultaneous start
    start = 1'b1; flush = 1'b1; op = OP_MULTU; a = 32'd9; b = 32'd9;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {63'd0, busy}, 64'd0);
    repeat (5) @(negedge clk);
    chk("flush_start_hilo", {hi, lo}, {32'd0, 32'd30});

    // Writeback wins over MTHI in the DONE cycle; next cycle MTHI lands
    issue("mult_2x3", OP_MULT, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 3);
    @(negedge clk);
    @(negedge clk); hi_we = 1'b1; wdata = 32'hAAAA;
    @(negedge clk);
    @(negedge clk); hi_we = 1'b0;
    chk("mthi_after_wb", {32'd0, hi}, {32'd0, 32'hAAAA});
    drain();

    // Reset in the middle of a divide, then start on the first edge after release
    start = 1'b1; op = OP_DIV; a = 32'd5000; b = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_flags", {62'd0, done, div_zero}, 64'd0);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    issue("post_rst_divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
